// File: rtl/framebuffer_writer_pkg.sv
// Shared types and default geometry for the double-buffered framebuffer writer.
package framebuffer_writer_pkg;

  localparam int DISPLAY_WIDTH  = 320;
  localparam int DISPLAY_HEIGHT = 240;
  localparam int PIX_ADDR_BITS  = 17;
  localparam int ADDR_BITS      = PIX_ADDR_BITS + 1;

  typedef logic [3:0] pixel_t;

  typedef enum logic {
    FILL      = 1'b0,
    WAIT_SWAP = 1'b1
  } state_t;

endpackage

// File: rtl/framebuffer_writer_if.sv
// Pixel stream, BRAM write port and bank/frame status of the framebuffer writer.
interface framebuffer_writer_if #(
  parameter int X_BITS    = 9,
  parameter int Y_BITS    = 8,
  parameter int ADDR_BITS = 18
);
  import framebuffer_writer_pkg::*;

  logic                 pix_valid_in;
  pixel_t               pix_data_in;
  logic                 pix_ready_out;
  logic [X_BITS-1:0]    pix_x_out;
  logic [Y_BITS-1:0]    pix_y_out;
  logic                 vsync_in;
  logic                 wr_en_out;
  logic [ADDR_BITS-1:0] wr_addr_out;
  pixel_t               wr_data_out;
  logic                 front_bank_out;
  logic                 frame_start_out;
  logic [15:0]          frame_count_out;

  modport slave (
    input  pix_valid_in, pix_data_in, vsync_in,
    output pix_ready_out, pix_x_out, pix_y_out, wr_en_out, wr_addr_out,
           wr_data_out, front_bank_out, frame_start_out, frame_count_out
  );

  modport master (
    output pix_valid_in, pix_data_in, vsync_in,
    input  pix_ready_out, pix_x_out, pix_y_out, wr_en_out, wr_addr_out,
           wr_data_out, front_bank_out, frame_start_out, frame_count_out
  );

endinterface

// File: rtl/framebuffer_writer_raster_counter.sv
// Raster position tracker: linear address plus x/y, advanced once per accepted pixel.
module raster_counter #(
  parameter int WIDTH         = 320,
  parameter int HEIGHT        = 240,
  parameter int PIX_ADDR_BITS = 17,
  parameter int X_BITS        = 9,
  parameter int Y_BITS        = 8
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     advance_i,
  input  logic                     clear_i,
  output logic [PIX_ADDR_BITS-1:0] lin_o,
  output logic [X_BITS-1:0]        x_o,
  output logic [Y_BITS-1:0]        y_o,
  output logic                     last_o
);

  localparam logic [PIX_ADDR_BITS-1:0] LIN_LAST = PIX_ADDR_BITS'(WIDTH * HEIGHT - 1);
  localparam logic [X_BITS-1:0]        X_LAST   = X_BITS'(WIDTH - 1);

  logic [PIX_ADDR_BITS-1:0] lin_q, lin_d;
  logic [X_BITS-1:0]        x_q, x_d;
  logic [Y_BITS-1:0]        y_q, y_d;

  assign last_o = (lin_q == LIN_LAST);
  assign lin_o  = lin_q;
  assign x_o    = x_q;
  assign y_o    = y_q;

  // Next raster position; the linear address is a running count so no multiplier is needed.
  always_comb begin
    lin_d = lin_q;
    x_d   = x_q;
    y_d   = y_q;
    if (clear_i || (advance_i && last_o)) begin
      lin_d = '0;
      x_d   = '0;
      y_d   = '0;
    end else if (advance_i) begin
      lin_d = lin_q + PIX_ADDR_BITS'(1);
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = y_q + Y_BITS'(1);
      end else begin
        x_d = x_q + X_BITS'(1);
        y_d = y_q;
      end
    end else begin
      lin_d = lin_q;
    end
  end

  // Raster position registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      lin_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      lin_q <= lin_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

endmodule

// File: rtl/framebuffer_writer.sv
// Double-buffered framebuffer write controller: fills the back bank in raster order and
// swaps banks on the first vsync rising edge after a frame completes.
module framebuffer_writer
  import framebuffer_writer_pkg::*;
#(
  parameter int WIDTH         = DISPLAY_WIDTH,
  parameter int HEIGHT        = DISPLAY_HEIGHT,
  parameter int PIX_ADDR_BITS = framebuffer_writer_pkg::PIX_ADDR_BITS,
  parameter int X_BITS        = 9,
  parameter int Y_BITS        = 8
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  framebuffer_writer_if.slave  bus
);

  state_t                 state_q, state_d;
  logic                   vsync_q;
  logic                   front_bank_q, front_bank_d;
  logic [15:0]            frame_count_q, frame_count_d;
  logic                   frame_start_q, frame_start_d;
  logic                   wr_en_q, wr_en_d;
  logic [PIX_ADDR_BITS:0] wr_addr_q, wr_addr_d;
  pixel_t                 wr_data_q, wr_data_d;

  logic                     accept;
  logic                     vsync_rise;
  logic                     last;
  logic [PIX_ADDR_BITS-1:0] lin;
  logic [X_BITS-1:0]        x;
  logic [Y_BITS-1:0]        y;

  assign accept     = (state_q == FILL) && bus.pix_valid_in;
  assign vsync_rise = bus.vsync_in && !vsync_q;

  raster_counter #(
    .WIDTH         (WIDTH),
    .HEIGHT        (HEIGHT),
    .PIX_ADDR_BITS (PIX_ADDR_BITS),
    .X_BITS        (X_BITS),
    .Y_BITS        (Y_BITS)
  ) u_raster (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .advance_i (accept),
    .clear_i   (1'b0),
    .lin_o     (lin),
    .x_o       (x),
    .y_o       (y),
    .last_o    (last)
  );

  // Next-state, write-port and bank-swap decode.
  always_comb begin
    state_d       = state_q;
    front_bank_d  = front_bank_q;
    frame_count_d = frame_count_q;
    frame_start_d = 1'b0;
    wr_en_d       = accept;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    if (accept) begin
      wr_addr_d = {~front_bank_q, lin};
      wr_data_d = bus.pix_data_in;
    end else begin
      wr_addr_d = wr_addr_q;
    end
    // An edge coinciding with the final acceptance is seen while still in FILL and ignored.
    case (state_q)
      FILL: begin
        if (accept && last) begin
          state_d = WAIT_SWAP;
        end else begin
          state_d = FILL;
        end
      end
      WAIT_SWAP: begin
        if (vsync_rise) begin
          state_d       = FILL;
          front_bank_d  = ~front_bank_q;
          frame_count_d = frame_count_q + 16'd1;
          frame_start_d = 1'b1;
        end else begin
          state_d = WAIT_SWAP;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // State, vsync history and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q       <= FILL;
      vsync_q       <= 1'b0;
      front_bank_q  <= 1'b0;
      frame_count_q <= 16'd0;
      frame_start_q <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= 4'd0;
    end else begin
      state_q       <= state_d;
      vsync_q       <= bus.vsync_in;
      front_bank_q  <= front_bank_d;
      frame_count_q <= frame_count_d;
      frame_start_q <= frame_start_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
    end
  end

  assign bus.pix_ready_out   = (state_q == FILL);
  assign bus.pix_x_out       = x;
  assign bus.pix_y_out       = y;
  assign bus.wr_en_out       = wr_en_q;
  assign bus.wr_addr_out     = wr_addr_q;
  assign bus.wr_data_out     = wr_data_q;
  assign bus.front_bank_out  = front_bank_q;
  assign bus.frame_start_out = frame_start_q;
  assign bus.frame_count_out = frame_count_q;

endmodule
